// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode and buffer-state enums, data width,
// and the ALU evaluation function.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Results wrap modulo 2^DATA_W; no carry or borrow is reported.
    function automatic logic [DATA_W-1:0] alu_eval(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        case (op)
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND:     res = a & b;
            default: res = a | b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: grants the first set request found searching
// upward from ptr with wrap-around, only while enable is high.
module alu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a single-entry
// tagged response buffer. Define ALU_RR_ARBITER_STATS_EN to add the op_count port.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [8*NUM_REQ-1:0]  req_a,
    input  logic [8*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    buf_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     id_q;

    logic                can_accept;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                transfer;

    logic [1:0]          op_arr [NUM_REQ];
    logic [DATA_W-1:0]   a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   b_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[2*gi +: 2];
            assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // Gating with rst_n keeps req_ready low for the whole reset interval.
    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .enable    (can_accept && rst_n),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (transfer)
    );

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (transfer) begin
            state_d = FULL;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // A full buffer may refill in the same cycle it is drained.
    always_comb begin
        rsp_valid  = (state_q == FULL);
        can_accept = (state_q == EMPTY) || rsp_ready;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (transfer) begin
                data_q <= alu_eval(alu_op_e'(op_arr[grant_idx]),
                                   a_arr[grant_idx], b_arr[grant_idx]);
                id_q   <= grant_idx;
            end
        end
    end

    assign rsp_data = data_q;
    assign rsp_id   = id_q;

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (transfer) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed, table-driven bench for alu_rr_arbiter (4 requesters) with hand sequences
// for backpressure and asynchronous reset.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic [15:0] op_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_ops = 0;

    alu_rr_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
`ifdef ALU_RR_ARBITER_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1: drive, check req_ready mid-cycle, then outputs after the edge.
    task automatic step(input vec_t v, input int n);
        req_valid = v.valid;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = v.rr;
        #3;
        check("req_ready", 32'(req_ready), 32'(v.exp_ready));
        if (v.exp_ready != 4'b0000) exp_ops++;
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(v.exp_v));
        check("rsp_data", 32'(rsp_data), 32'(v.exp_d));
        check("rsp_id", 32'(rsp_id), 32'(v.exp_id));
        $display("vec %0d: valid=%b rr=%b ready=%b rsp_valid=%b data=%02h id=%0d",
                 n, v.valid, v.rr, req_ready, rsp_valid, rsp_data, rsp_id);
    endtask

    initial begin
        vec_t v;
        // valid  op     a             b             rr    ready    v     d      id
        tbl[0]  = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b0001, 1'b1, 8'h0C, 2'd0};
        tbl[1]  = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b0010, 1'b1, 8'hFE, 2'd1};
        tbl[2]  = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b0100, 1'b1, 8'h05, 2'd2};
        tbl[3]  = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b1000, 1'b1, 8'h07, 2'd3};
        tbl[4]  = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b0001, 1'b1, 8'h0C, 2'd0};
        tbl[5]  = '{4'h4, 8'h00, 32'h00F00000, 32'h00200000, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd2};
        tbl[6]  = '{4'h1, 8'h00, 32'h00000005, 32'h00000007, 1'b1, 4'b0001, 1'b1, 8'h0C, 2'd0};
        tbl[7]  = '{4'h1, 8'h01, 32'h00000005, 32'h00000007, 1'b1, 4'b0001, 1'b1, 8'hFE, 2'd0};
        tbl[8]  = '{4'h1, 8'h02, 32'h00000005, 32'h00000007, 1'b1, 4'b0001, 1'b1, 8'h05, 2'd0};
        tbl[9]  = '{4'h1, 8'h03, 32'h00000005, 32'h00000007, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0};
        tbl[10] = '{4'h0, 8'h00, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h07, 2'd0};
        tbl[11] = '{4'h0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h07, 2'd0};
        tbl[12] = '{4'h2, 8'h00, 32'h0000FF00, 32'h00000100, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd1};
        tbl[13] = '{4'h8, 8'h40, 32'h00000000, 32'h01000000, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3};

        // Reset with every requester asserting valid: nothing may be granted.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        req_valid = 4'h0;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) step(tbl[i], i);

        // Backpressure: fill with requester 2, then stall requester 1 for three cycles.
        v = '{4'h4, 8'h00, 32'h00100000, 32'h00220000, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2};
        step(v, 100);
        for (int i = 0; i < 3; i++) begin
            v = '{4'h2, 8'h00, 32'h00000100, 32'h00000200, 1'b0, 4'b0000, 1'b1, 8'h32, 2'd2};
            step(v, 101 + i);
        end
        v = '{4'h2, 8'h00, 32'h00000100, 32'h00000200, 1'b1, 4'b0010, 1'b1, 8'h03, 2'd1};
        step(v, 104);

        // Asynchronous reset while the buffer is full, away from any clock edge.
        req_valid = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rsp_data", 32'(rsp_data), 32'h0);
        check("async_rsp_id", 32'(rsp_id), 32'h0);
        exp_ops = 0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{4'hF, 8'hE4, 32'h05050505, 32'h07070707, 1'b1, 4'b0001, 1'b1, 8'h0C, 2'd0};
        step(v, 105);

`ifdef ALU_RR_ARBITER_STATS_EN
        check("op_count", 32'(op_count), 32'(exp_ops));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
